// File: rtl/bus_split_arbiter.sv
// bus_split_arbiter: two-initiator arbiter for the bridged serial bus with
// split-transaction support. A target may split a transfer; the bus then goes
// back to arbitration, and the split target later reclaims it with split_req
// to drive the completion under split_grant.
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration between
// initiators; left undefined, initiator 0 has fixed priority over initiator 1.
//
// Handshake: reqN is a level request held by the initiator for the whole
// transfer. grantN rises one cycle after reqN is seen in idle and stays high
// until the target pulses target_ack / target_split_ack, the initiator drops
// reqN (abort), or the hold timer expires. Every release leaves at least one
// idle cycle before the next owner is granted.
module bus_split_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       target_ack,
  input  logic       target_split_ack,
  input  logic       split_req,
  output logic       grant0,
  output logic       grant1,
  output logic       split_grant,
  output logic       bus_owner,
  output logic       bus_busy,
  output logic       split_pending,
  output logic       timeout_pulse,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_SPLIT = 2'd2
  } arb_state_t;

  localparam int CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             split_owner;
  logic             elig0;
  logic             elig1;
  logic             pick;
  logic             owner_req;
  logic             timeout_hit;
`ifdef ARB_ROUND_ROBIN_EN
  logic             last_owner;
`endif

  assign dbg_state = state;

  // Eligibility masking, arbitration pick, owner request and hold-timer expiry.
  always_comb begin
    elig0       = req0 & ~(split_pending & ~split_owner);
    elig1       = req1 & ~(split_pending &  split_owner);
    owner_req   = bus_owner ? req1 : req0;
    // cnt counts completed hold cycles minus one; this edge ends cycle TIMEOUT_CYCLES.
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
`ifdef ARB_ROUND_ROBIN_EN
    if (elig0 && elig1) pick = ~last_owner;
    else                pick = ~elig0;
`else
    pick = ~elig0;
`endif
  end

  // Arbiter FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      cnt           <= '0;
      split_owner   <= 1'b0;
      split_pending <= 1'b0;
      grant0        <= 1'b0;
      grant1        <= 1'b0;
      split_grant   <= 1'b0;
      bus_owner     <= 1'b0;
      bus_busy      <= 1'b0;
      timeout_pulse <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner    <= 1'b0;
`endif
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        ARB_IDLE: begin
          cnt <= '0;
          if (split_pending && split_req) begin
            state       <= ARB_SPLIT;
            split_grant <= 1'b1;
            bus_busy    <= 1'b1;
            bus_owner   <= split_owner;
          end else if (elig0 || elig1) begin
            state      <= ARB_GRANT;
            grant0     <= ~pick;
            grant1     <= pick;
            bus_busy   <= 1'b1;
            bus_owner  <= pick;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= pick;
`endif
          end
        end
        ARB_GRANT: begin
          cnt <= cnt + CNT_ONE;
          // target_ack has precedence, so a simultaneous split_ack records nothing.
          if (target_ack || target_split_ack || !owner_req || timeout_hit) begin
            state    <= ARB_IDLE;
            grant0   <= 1'b0;
            grant1   <= 1'b0;
            bus_busy <= 1'b0;
            cnt      <= '0;
            if (!target_ack && target_split_ack) begin
              split_pending <= 1'b1;
              split_owner   <= bus_owner;
            end
            if (!target_ack && !target_split_ack && owner_req) timeout_pulse <= 1'b1;
          end
        end
        ARB_SPLIT: begin
          cnt <= cnt + CNT_ONE;
          // split_req falling and target_split_ack do not end the completion phase.
          if (target_ack || timeout_hit) begin
            state         <= ARB_IDLE;
            split_grant   <= 1'b0;
            bus_busy      <= 1'b0;
            split_pending <= 1'b0;
            cnt           <= '0;
            if (!target_ack) timeout_pulse <= 1'b1;
          end
        end
        default: begin
          state       <= ARB_IDLE;
          grant0      <= 1'b0;
          grant1      <= 1'b0;
          split_grant <= 1'b0;
          bus_busy    <= 1'b0;
          cnt         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Testbench for bus_split_arbiter (hold timeout set to 4 cycles).
// Each step drives one cycle of inputs, pushes the outputs expected after the
// next rising edge onto exp_q, and pops/compares them 1 time unit after it.
// Expected vector order: grant0 grant1 split_grant bus_busy split_pending
// timeout_pulse owner (owner only meaningful, and compared, while busy).
module tb_bus_split_arbiter;

  localparam int unsigned TO = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       req0;
  logic       req1;
  logic       target_ack;
  logic       target_split_ack;
  logic       split_req;
  logic       grant0;
  logic       grant1;
  logic       split_grant;
  logic       bus_owner;
  logic       bus_busy;
  logic       split_pending;
  logic       timeout_pulse;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bus_split_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .req0             (req0),
    .req1             (req1),
    .target_ack       (target_ack),
    .target_split_ack (target_split_ack),
    .split_req        (split_req),
    .grant0           (grant0),
    .grant1           (grant1),
    .split_grant      (split_grant),
    .bus_owner        (bus_owner),
    .bus_busy         (bus_busy),
    .split_pending    (split_pending),
    .timeout_pulse    (timeout_pulse),
    .dbg_state        (dbg_state)
  );

  function automatic logic [6:0] ev(input logic g0, input logic g1, input logic sg,
                                    input logic sp, input logic tp, input logic own);
    return {g0, g1, sg, g0 | g1 | sg, sp, tp, own};
  endfunction

  // Initiator grant, idle, and split-grant expectation shorthands.
  function automatic logic [6:0] gv(input logic own, input logic sp);
    return ev(~own, own, 1'b0, sp, 1'b0, own);
  endfunction
  function automatic logic [6:0] iv(input logic sp, input logic tp);
    return ev(1'b0, 1'b0, 1'b0, sp, tp, 1'b0);
  endfunction
  function automatic logic [6:0] sv(input logic own, input logic sp);
    return ev(1'b0, 1'b0, 1'b1, sp, 1'b0, own);
  endfunction

  task automatic check_eq(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and score the outputs after the edge.
  task automatic step(input string tag, input logic r, input logic r0, input logic r1,
                      input logic ack, input logic sack, input logic sreq,
                      input logic [6:0] exp);
    logic [6:0] want;
    logic [6:0] obs;
    rst = r; req0 = r0; req1 = r1;
    target_ack = ack; target_split_ack = sack; split_req = sreq;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    obs  = {grant0, grant1, split_grant, bus_busy, split_pending, timeout_pulse,
            bus_busy ? bus_owner : 1'b0};
    check_eq(tag, obs, want);
  endtask

  // Three granted cycles followed by an ack cycle.
  task automatic xfer(input string tag, input logic r0, input logic r1,
                      input logic own, input logic sp);
    for (int i = 0; i < 3; i++) step(tag, 1'b0, r0, r1, 1'b0, 1'b0, 1'b0, gv(own, sp));
    step({tag, "_ack"}, 1'b0, r0, r1, 1'b1, 1'b0, 1'b0, iv(sp, 1'b0));
  endtask

  initial begin
    // Reset, including reset with a request already present.
    step("reset", 1, 0, 0, 0, 0, 0, iv(0, 0));
    step("reset_req", 1, 1, 1, 0, 0, 0, iv(0, 0));
    check_eq("reset_state", {5'd0, dbg_state}, 7'd0);
    step("idle", 0, 0, 0, 0, 0, 0, iv(0, 0));

    // Single request; ack lands on the same edge the timer would expire: ack wins.
    for (int i = 0; i < 4; i++) step("g0_hold", 0, 1, 0, 0, 0, 0, gv(0, 0));
    step("g0_ack", 0, 1, 0, 1, 0, 0, iv(0, 0));
    step("g0_idle", 0, 0, 0, 0, 0, 0, iv(0, 0));

    // Both held: fixed priority keeps initiator 0, round-robin alternates.
    xfer("both_a", 1, 1, RR, 0);
    xfer("both_b", 1, 1, 1'b0, 0);
    xfer("only1", 0, 1, 1'b1, 0);
    step("both_idle", 0, 0, 0, 0, 0, 0, iv(0, 0));

    // Split by initiator 1, initiator 0 served meanwhile, completion afterwards.
    step("s_g1", 0, 0, 1, 0, 0, 0, gv(1, 0));
    step("s_g1", 0, 0, 1, 0, 0, 0, gv(1, 0));
    step("s_sack", 0, 0, 1, 0, 1, 0, iv(1, 0));
    step("s_g0", 0, 1, 1, 0, 0, 0, gv(0, 1));
    step("s_g0_sreq", 0, 1, 1, 0, 0, 1, gv(0, 1));
    step("s_g0_ack", 0, 1, 1, 1, 0, 1, iv(1, 0));
    step("s_sgrant", 0, 1, 1, 0, 0, 1, sv(1, 1));
    check_eq("state_split", {5'd0, dbg_state}, 7'd2);
    step("s_hold", 0, 1, 1, 0, 1, 0, sv(1, 1));
    step("s_done", 0, 1, 1, 1, 0, 0, iv(0, 0));
    step("s_regrant1", 0, 0, 1, 0, 0, 0, gv(1, 0));
    step("abort", 0, 0, 0, 0, 0, 0, iv(0, 0));
    step("sreq_ignored", 0, 0, 0, 0, 0, 1, iv(0, 0));

    // Split owner's held request stays masked until the split completes.
    step("m_g1", 0, 0, 1, 0, 0, 0, gv(1, 0));
    step("m_sack", 0, 0, 1, 0, 1, 0, iv(1, 0));
    for (int i = 0; i < 3; i++) step("m_masked", 0, 0, 1, 0, 0, 0, iv(1, 0));
    step("m_sgrant", 0, 0, 1, 0, 0, 1, sv(1, 1));
    step("m_done", 0, 0, 1, 1, 0, 1, iv(0, 0));
    step("m_regrant", 0, 0, 1, 0, 0, 0, gv(1, 0));
    step("m_ack", 0, 0, 1, 1, 0, 0, iv(0, 0));
    step("m_idle", 0, 0, 0, 0, 0, 0, iv(0, 0));

    // Grant timeout: four cycles held, one pulse, regrant after one idle cycle.
    for (int i = 0; i < 4; i++) step("to_hold", 0, 1, 0, 0, 0, 0, gv(0, 0));
    step("to_pulse", 0, 1, 0, 0, 0, 0, iv(0, 1));
    step("to_regrant", 0, 1, 0, 0, 0, 0, gv(0, 0));
    step("to_ack", 0, 1, 0, 1, 0, 0, iv(0, 0));
    step("to_idle", 0, 0, 0, 0, 0, 0, iv(0, 0));

    // Split-phase timeout discards the pending split.
    step("st_g0", 0, 1, 0, 0, 0, 0, gv(0, 0));
    step("st_sack", 0, 1, 0, 0, 1, 0, iv(1, 0));
    for (int i = 0; i < 4; i++) step("st_hold", 0, 0, 0, 0, 0, 1, sv(0, 1));
    step("st_pulse", 0, 0, 0, 0, 0, 1, iv(0, 1));
    step("st_idle", 0, 0, 0, 0, 0, 1, iv(0, 0));

    // Reset during the split phase drops everything and forgets the split.
    step("r_g0", 0, 1, 0, 0, 0, 0, gv(0, 0));
    step("r_sack", 0, 1, 0, 0, 1, 0, iv(1, 0));
    step("r_sgrant", 0, 0, 0, 0, 0, 1, sv(0, 1));
    step("r_reset", 1, 0, 0, 0, 0, 1, iv(0, 0));
    step("r_sreq_ign", 0, 0, 0, 0, 0, 1, iv(0, 0));
    step("r_sreq_ign2", 0, 0, 0, 0, 0, 1, iv(0, 0));
    check_eq("r_state", {5'd0, dbg_state}, 7'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
